mult_pipe: RTL and testbench
============================

Name: mult_pipe

Overview:
- Parametrised, pipelined integer multiplier. It is the next generation of the team's 4-bit combinational partial-product/compressor/prefix-adder multiplier.
- Generalised to WIDTH-bit operands, with a per-transaction signed/unsigned mode and a pass-through tag.
- Three register stages with valid/ready flow control. Sustains one product per cycle under no backpressure.
- Sits between operand producers and the datapath consumers that need full 2*WIDTH products.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32; product is 2*WIDTH bits.
- TAG_W, 4, width of the opaque sideband tag carried with each operation; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = treat a and b as two's complement; 0 = unsigned.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_p  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of the operation that produced out_p.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert by the environment):
  - all stage valid bits, out_valid, out_p and out_tag go to 0.
  - Stage data registers other than the output stage need not be reset.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_a, in_b, in_signed and in_tag are sampled only on an input transfer.
- Stages:
  - S1: registers operands, mode and tag.
  - S2: generates WIDTH partial products and reduces them with FA/HA carry-save compression to two 2*WIDTH rows. Registers both rows, the mode and the tag.
  - S3: adds the two rows with a parallel-prefix adder (grey/black cells, carry-out discarded). Registers the result into out_p/out_tag.
- Latency: a result appears on out_valid exactly 3 cycles after its input transfer when not stalled.
- Elastic pipeline, per stage k: stage k loads when (stage k empty) or (stage k is emptying this cycle).
  - S3 empties on an output transfer.
  - S1 and S2 empty when the next stage loads.
  - in_ready = !S1_valid || S1 advancing. This is combinational from out_ready; no other combinational in-to-out paths exist.
- Capacity: 3 operations in flight. With out_ready held low, exactly 3 inputs are accepted, then in_ready = 0.
- Output hold: while out_valid && !out_ready, out_p and out_tag stay stable.
- Ordering: results leave strictly in acceptance order. No drop, no duplicate.
- Signed mode (in_signed = 1): out_p = signed(a) * signed(b) in 2*WIDTH two's complement. Use Baugh-Wooley correction or sign extension of partial products.
- Unsigned mode: out_p = a * b, zero-extended.
- The product always fits in 2*WIDTH bits in both modes; no overflow flag.
- Simultaneous accept and emit in the same cycle is legal and sustains full throughput.
- Reset mid-operation clears all in-flight operations. No result of a pre-reset operation is ever emitted after reset.
- Mode may change every beat. Each operation uses its own latched mode.

Decomposition:
- Shared package mult_pkg:
  - localparams for the stage count (3) and the product width function (2*WIDTH).
  - An enum for mode (MODE_UNSIGNED = 0, MODE_SIGNED = 1).
- Sub-module prefix_adder_w:
  - parametrised width N, Sklansky-style prefix tree of grey/black cells, purely combinational.
  - Instantiated once in S3.
  - Reusable by later blocks.
- The compressor tree is generated inline with for-generate; there is no separate module.

Test Plan:
- Unsigned corners, WIDTH = 8: (255,255) -> 0xFE01; (0,200) -> 0x0000; (1,173) -> 0x00AD. Each appears on out_valid exactly 3 cycles after acceptance.
- Signed corners, WIDTH = 8:
  - (-128,-128) -> 0x4000
  - (-128,127) -> 0xC080
  - (-1,1) -> 0xFFFF
  - (-1,-1) -> 0x0001
  - Interleave with unsigned (0xFF,0xFF) -> 0xFE01 on alternate beats.
- Throughput: 16 back-to-back beats, out_ready = 1, tags 0..15 -> 16 consecutive out_valid cycles starting at cycle 3, tags in order, in_ready never drops.
- Backpressure: out_ready low for 6 cycles while driving 5 beats -> exactly 3 accepted, then in_ready = 0. out_p/out_tag stable while stalled. After release, all 5 results arrive in order, no loss or duplicate.
- Reset mid-flight: assert rst_n low while 2 operations are in flight -> out_valid/out_p/out_tag = 0 immediately. After deassert, no stale result appears; a new op (3,5) -> 0x000F three cycles later.
- Parameter sweep: WIDTH = 4 exhaustive (256 pairs × 2 modes) and WIDTH = 16 random with 10k vectors, checked against a behavioural reference with random out_ready stalls.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined multiplier family.
package mult_pkg;

    // Register stages between operand capture and product output.
    localparam int STAGES = 3;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

    // Full product width for a given operand width.
    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/prefix_adder_w.sv
// Sklansky parallel-prefix adder, N bits, carry-out discarded, purely combinational.
module prefix_adder_w #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    localparam int LVLS = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] g0;
    logic [N-1:0] p0;
    logic [N-1:0] g_fin;
    logic         unused_prefix;

    assign g0 = a & b;
    assign p0 = a ^ b;

    genvar l, i;
    generate
        for (l = 0; l < LVLS; l++) begin : g_lvl
            logic [N-1:0] g_in;
            logic [N-1:0] p_in;
            logic [N-1:0] g_o;
            logic [N-1:0] p_o;

            if (l == 0) begin : g_first
                assign g_in = g0;
                assign p_in = p0;
            end else begin : g_next
                assign g_in = g_lvl[l-1].g_o;
                assign p_in = g_lvl[l-1].p_o;
            end

            for (i = 0; i < N; i++) begin : g_bit
                if (((i >> l) & 1) == 1) begin : g_cell
                    // Top bit of the lower half of this 2^(l+1) block.
                    localparam int J = ((i >> l) << l) - 1;
                    if ((i >> (l + 1)) == 0) begin : g_grey
                        // Span already reaches bit 0: only the generate term matters.
                        assign g_o[i] = g_in[i] | (p_in[i] & g_in[J]);
                        assign p_o[i] = 1'b0;
                    end else begin : g_black
                        assign g_o[i] = g_in[i] | (p_in[i] & g_in[J]);
                        assign p_o[i] = p_in[i] & p_in[J];
                    end
                end else begin : g_pass
                    assign g_o[i] = g_in[i];
                    assign p_o[i] = p_in[i];
                end
            end
        end
    endgenerate

    assign g_fin = g_lvl[LVLS-1].g_o;

    // Carry into bit i is the group generate of bits [i-1:0].
    assign sum = p0 ^ {g_fin[N-2:0], 1'b0};

    // Final carry-out and group propagates are not needed by a modular add.
    assign unused_prefix = ^{g_fin[N-1], g_lvl[LVLS-1].p_o};

endmodule

// File: rtl/mult_pipe.sv
// Three-stage elastic multiplier: capture, partial products + carry-save, prefix add.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW = prod_w(WIDTH);

    logic                     vld_p1_q, vld_p1_d;
    logic                     vld_p2_q, vld_p2_d;
    logic                     vld_p3_q, vld_p3_d;
    logic signed [WIDTH-1:0]  a_p1_q, a_p1_d;
    logic signed [WIDTH-1:0]  b_p1_q, b_p1_d;
    mode_e                    mode_p1_q, mode_p1_d;
    mode_e                    mode_p2_q, mode_p2_d;
    logic [TAG_W-1:0]         tag_p1_q, tag_p1_d;
    logic [TAG_W-1:0]         tag_p2_q, tag_p2_d;
    logic [TAG_W-1:0]         tag_p3_q, tag_p3_d;
    logic [PW-1:0]            sum_p2_q, sum_p2_d;
    logic [PW-1:0]            carry_p2_q, carry_p2_d;
    logic [PW-1:0]            p_p3_q, p_p3_d;

    logic                     s1_ready, s2_ready, s3_ready;
    logic                     is_signed;
    logic [PW-1:0]            a_ext;
    logic [PW-1:0]            add_sum;
    logic                     unused_mode_p2;

    // A stage accepts when empty or when its content moves on this cycle.
    assign s3_ready = !vld_p3_q || out_ready;
    assign s2_ready = !vld_p2_q || s3_ready;
    assign s1_ready = !vld_p1_q || s2_ready;
    assign in_ready = s1_ready;

    // ---- S1 -> S2: partial products and carry-save reduction ----
    assign is_signed = (mode_p1_q == MODE_SIGNED);
    assign a_ext     = {{WIDTH{a_p1_q[WIDTH-1] & is_signed}}, a_p1_q};

    // Rows 0..WIDTH-1 are the shifted multiplicands; the multiplier MSB carries
    // negative weight in signed mode, so its row is inverted and the +1 of the
    // two's-complement negation is supplied by the extra row WIDTH.
    genvar r, k;
    generate
        for (r = 0; r <= WIDTH; r++) begin : g_pp
            logic [PW-1:0] row;
            if (r < WIDTH - 1) begin : g_plain
                assign row = b_p1_q[r] ? (a_ext << r) : '0;
            end else if (r == WIDTH - 1) begin : g_msb
                assign row = !b_p1_q[r] ? '0 : (is_signed ? ~(a_ext << r) : (a_ext << r));
            end else begin : g_corr
                assign row = {{(PW-1){1'b0}}, b_p1_q[WIDTH-1] & is_signed};
            end
        end

        // Chain of full-adder rows folding one partial product per level.
        for (k = 2; k <= WIDTH; k++) begin : g_csa
            logic [PW-1:0] x, y, z, s_o, c_o, maj;
            logic          unused_msb;
            if (k == 2) begin : g_head
                assign x = g_pp[0].row;
                assign y = g_pp[1].row;
            end else begin : g_link
                assign x = g_csa[k-1].s_o;
                assign y = g_csa[k-1].c_o;
            end
            assign z          = g_pp[k].row;
            assign s_o        = x ^ y ^ z;
            assign maj        = (x & y) | (x & z) | (y & z);
            assign c_o        = {maj[PW-2:0], 1'b0};
            assign unused_msb = maj[PW-1];
        end
    endgenerate

    // ---- S2 -> S3: final carry-propagate add ----
    prefix_adder_w #(.N(PW)) u_add (
        .a   (sum_p2_q),
        .b   (carry_p2_q),
        .sum (add_sum)
    );

    // The rows already encode the mode; the registered copy is kept for visibility.
    assign unused_mode_p2 = mode_p2_q;

    // Next-state for every stage: hold unless the stage is allowed to load.
    always_comb begin
        vld_p1_d   = vld_p1_q;
        a_p1_d     = a_p1_q;
        b_p1_d     = b_p1_q;
        mode_p1_d  = mode_p1_q;
        tag_p1_d   = tag_p1_q;
        vld_p2_d   = vld_p2_q;
        sum_p2_d   = sum_p2_q;
        carry_p2_d = carry_p2_q;
        mode_p2_d  = mode_p2_q;
        tag_p2_d   = tag_p2_q;
        vld_p3_d   = vld_p3_q;
        p_p3_d     = p_p3_q;
        tag_p3_d   = tag_p3_q;

        // ---- S1: operand capture ----
        if (s1_ready) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
                a_p1_d    = in_a;
                b_p1_d    = in_b;
                mode_p1_d = in_signed ? MODE_SIGNED : MODE_UNSIGNED;
                tag_p1_d  = in_tag;
            end
        end

        // ---- S2: carry-save rows ----
        if (s2_ready) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                sum_p2_d   = g_csa[WIDTH].s_o;
                carry_p2_d = g_csa[WIDTH].c_o;
                mode_p2_d  = mode_p1_q;
                tag_p2_d   = tag_p1_q;
            end
        end

        // ---- S3: product register; data only moves with a valid beat so a stall holds it ----
        if (s3_ready) begin
            vld_p3_d = vld_p2_q;
            if (vld_p2_q) begin
                p_p3_d   = add_sum;
                tag_p3_d = tag_p2_q;
            end
        end
    end

    // Control and output-stage registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            p_p3_q   <= '0;
            tag_p3_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            p_p3_q   <= p_p3_d;
            tag_p3_q <= tag_p3_d;
        end
    end

    // Internal datapath registers, qualified by their valid bits and never reset.
    always_ff @(posedge clk) begin
        a_p1_q     <= a_p1_d;
        b_p1_q     <= b_p1_d;
        mode_p1_q  <= mode_p1_d;
        tag_p1_q   <= tag_p1_d;
        sum_p2_q   <= sum_p2_d;
        carry_p2_q <= carry_p2_d;
        mode_p2_q  <= mode_p2_d;
        tag_p2_q   <= tag_p2_d;
    end

    assign out_valid = vld_p3_q;
    assign out_p     = p_p3_q;
    assign out_tag   = tag_p3_q;

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench: three widths (8, 4, 16) against an arithmetic reference model.
module tb_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] a_v  [3];
    logic [15:0] b_v  [3];
    logic [3:0]  tg_v [3];
    logic [2:0]  iv, sg, ordy;
    wire  [2:0]  ir, ov;
    wire  [15:0] p8;
    wire  [7:0]  p4;
    wire  [31:0] p16;
    wire  [3:0]  t8, t4, t16;

    mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(a_v[0][7:0]), .in_b(b_v[0][7:0]), .in_signed(sg[0]), .in_tag(tg_v[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_p(p8), .out_tag(t8));

    mult_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(a_v[1][3:0]), .in_b(b_v[1][3:0]), .in_signed(sg[1]), .in_tag(tg_v[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_p(p4), .out_tag(t4));

    mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(a_v[2]), .in_b(b_v[2]), .in_signed(sg[2]), .in_tag(tg_v[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_p(p16), .out_tag(t16));

    typedef struct {
        logic [63:0] p;
        logic [3:0]  tag;
        longint      cyc;
    } item_t;

    item_t       scb [3][$];
    int          n_vec = 0;
    int          n_err = 0;
    longint      cyc = 0;
    bit          chk_lat = 1'b0;
    bit          rnd_stall = 1'b0;
    int          acc_cnt [3];
    bit          held [3];
    logic [31:0] hp [3];
    logic [3:0]  ht [3];

    function automatic int wof(int d);
        return (d == 0) ? 8 : (d == 1) ? 4 : 16;
    endfunction

    function automatic logic [31:0] outp(int d);
        return (d == 0) ? {16'b0, p8} : (d == 1) ? {24'b0, p4} : p16;
    endfunction

    function automatic logic [3:0] outt(int d);
        return (d == 0) ? t8 : (d == 1) ? t4 : t16;
    endfunction

    // Reference: interpret operands as w-bit integers, multiply, keep 2w bits.
    function automatic logic [63:0] model(logic [15:0] a, logic [15:0] b, logic s, int w);
        longint      sa, sbv, msk;
        logic [63:0] m;
        msk = (longint'(1) << w) - 1;
        sa  = longint'({48'b0, a}) & msk;
        sbv = longint'({48'b0, b}) & msk;
        if (s && a[w-1]) sa  = sa  - (longint'(1) << w);
        if (s && b[w-1]) sbv = sbv - (longint'(1) << w);
        m = (64'd1 << (2 * w)) - 64'd1;
        return 64'(sa * sbv) & m;
    endfunction

    task automatic check(string nm, int d, logic [63:0] got, logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h, required %0h (t=%0t)", nm, d, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: scoreboard per DUT, evaluated mid-cycle when everything is settled.
    always @(negedge clk) begin
        item_t       e;
        logic [31:0] p;
        logic [3:0]  t;
        for (int d = 0; d < 3; d++) begin
            p = outp(d);
            t = outt(d);
            if (!rst_n) begin
                scb[d].delete();
                held[d] = 1'b0;
            end else begin
                if (held[d]) begin
                    check("hold_valid", d, 64'(ov[d]), 64'd1);
                    check("hold_p", d, 64'(p), 64'(hp[d]));
                    check("hold_tag", d, 64'(t), 64'(ht[d]));
                end
                if (ov[d] && ordy[d]) begin
                    check("out_valid_expected", d, 64'(ov[d]), 64'(scb[d].size() != 0));
                    if (scb[d].size() != 0) begin
                        e = scb[d].pop_front();
                        check("product", d, 64'(p), e.p);
                        check("tag", d, 64'(t), 64'(e.tag));
                        if (chk_lat) check("latency", d, 64'(cyc - e.cyc), 64'd3);
                    end
                end
                held[d] = ov[d] && !ordy[d];
                hp[d]   = p;
                ht[d]   = t;
                if (iv[d] && ir[d]) begin
                    scb[d].push_back('{model(a_v[d], b_v[d], sg[d], wof(d)), tg_v[d], cyc});
                    acc_cnt[d]++;
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int d, logic [15:0] a, logic [15:0] b, logic s, logic [3:0] t);
        bit ok;
        ok = 1'b0;
        a_v[d] = a; b_v[d] = b; sg[d] = s; tg_v[d] = t; iv[d] = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = ir[d];
            @(posedge clk);
            #1;
            if (rnd_stall) ordy[d] = ($urandom_range(3) != 0);
        end
        iv[d] = 1'b0;
        check("accept", d, 64'(ok), 64'd1);
    endtask

    task automatic drain(int d);
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        for (int k = 0; k < 50 && scb[d].size() != 0; k++) idle(1);
        check("drain", d, 64'(scb[d].size()), 64'd0);
    endtask

    task automatic rand_run(int d, int n);
        int start;
        start = acc_cnt[d];
        for (int k = 0; k < n * 8 + 200 && acc_cnt[d] - start < n; k++) begin
            iv[d]   = ($urandom_range(3) != 0);
            ordy[d] = ($urandom_range(3) != 0);
            a_v[d]  = 16'($urandom);
            b_v[d]  = 16'($urandom);
            sg[d]   = 1'($urandom);
            tg_v[d] = 4'($urandom);
            idle(1);
        end
        iv[d] = 1'b0;
        check("rand_accepted", d, 64'(acc_cnt[d] - start), 64'(n));
        drain(d);
    endtask

    initial begin
        logic [15:0] ba [5];
        logic [15:0] bb [5];
        int          a0;
        longint      c0;

        rst_n = 1'b0;
        iv    = '0;
        sg    = '0;
        ordy  = '1;
        for (int d = 0; d < 3; d++) begin
            a_v[d] = '0; b_v[d] = '0; tg_v[d] = '0; acc_cnt[d] = 0; held[d] = 1'b0;
        end

        // Hand-computed anchors for the reference model.
        check("pin_u_ff_ff", 0, model(16'hFF, 16'hFF, 1'b0, 8), 64'hFE01);
        check("pin_u_0_200", 0, model(16'd0, 16'd200, 1'b0, 8), 64'h0000);
        check("pin_u_1_173", 0, model(16'd1, 16'd173, 1'b0, 8), 64'h00AD);
        check("pin_s_m128_m128", 0, model(16'h80, 16'h80, 1'b1, 8), 64'h4000);
        check("pin_s_m128_127", 0, model(16'h80, 16'h7F, 1'b1, 8), 64'hC080);
        check("pin_s_m1_1", 0, model(16'hFF, 16'h01, 1'b1, 8), 64'hFFFF);
        check("pin_s_m1_m1", 0, model(16'hFF, 16'hFF, 1'b1, 8), 64'h0001);
        check("pin_w4_s_m8_7", 1, model(16'h8, 16'h7, 1'b1, 4), 64'hC8);
        check("pin_w16_s_min", 2, model(16'h8000, 16'h8000, 1'b1, 16), 64'h4000_0000);
        check("pin_w16_u_max", 2, model(16'hFFFF, 16'hFFFF, 1'b0, 16), 64'hFFFE_0001);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 0, 64'(ov[0]), 64'd0);
        check("rst_out_p", 0, 64'(p8), 64'd0);
        check("rst_out_tag", 0, 64'(t8), 64'd0);
        check("rst_in_ready", 0, 64'(ir[0]), 64'd1);
        check("rst_out_valid_w4", 1, 64'(ov[1]), 64'd0);
        check("rst_out_valid_w16", 2, 64'(ov[2]), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Unsigned and signed corners, interleaved modes, latency enforced.
        chk_lat = 1'b1;
        send(0, 16'd255, 16'd255, 1'b0, 4'd1);
        send(0, 16'd0,   16'd200, 1'b0, 4'd2);
        send(0, 16'd1,   16'd173, 1'b0, 4'd3);
        idle(5);
        send(0, 16'h80, 16'h80, 1'b1, 4'd4);
        send(0, 16'hFF, 16'hFF, 1'b0, 4'd5);
        send(0, 16'h80, 16'h7F, 1'b1, 4'd6);
        send(0, 16'hFF, 16'hFF, 1'b0, 4'd7);
        send(0, 16'hFF, 16'h01, 1'b1, 4'd8);
        send(0, 16'hFF, 16'hFF, 1'b0, 4'd9);
        send(0, 16'hFF, 16'hFF, 1'b1, 4'd10);
        idle(5);

        // Throughput: 16 back-to-back beats, each accepted on its first cycle.
        for (int t = 0; t < 16; t++) begin
            c0 = cyc;
            send(0, 16'($urandom), 16'($urandom), 1'($urandom), 4'(t));
            check("in_ready_b2b", 0, 64'(cyc - c0), 64'd1);
        end
        idle(5);
        chk_lat = 1'b0;

        // Backpressure: 6 stalled cycles, 5 beats offered, capacity 3.
        for (int i = 0; i < 5; i++) begin
            ba[i] = 16'($urandom);
            bb[i] = 16'($urandom);
        end
        a0 = acc_cnt[0];
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) send(0, ba[i], bb[i], 1'(i), 4'(i));
        a_v[0] = ba[3]; b_v[0] = bb[3]; sg[0] = 1'b1; tg_v[0] = 4'd3; iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_ready_full", 0, 64'(ir[0]), 64'd0);
            @(posedge clk);
            #1;
        end
        check("accepted_while_full", 0, 64'(acc_cnt[0] - a0), 64'd3);
        ordy[0] = 1'b1;
        send(0, ba[3], bb[3], 1'b1, 4'd3);
        send(0, ba[4], bb[4], 1'b0, 4'd4);
        drain(0);
        check("accepted_total", 0, 64'(acc_cnt[0] - a0), 64'd5);

        // Reset with two operations in flight, one of them on the output.
        ordy[0] = 1'b0;
        send(0, 16'd7, 16'd9, 1'b0, 4'd11);
        send(0, 16'd6, 16'd2, 1'b0, 4'd12);
        idle(1);
        check("pre_reset_out_valid", 0, 64'(ov[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 0, 64'(ov[0]), 64'd0);
        check("async_rst_out_p", 0, 64'(p8), 64'd0);
        check("async_rst_out_tag", 0, 64'(t8), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_result", 0, 64'(ov[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        send(0, 16'd3, 16'd5, 1'b0, 4'd9);
        repeat (3) @(negedge clk);
        check("post_rst_valid", 0, 64'(ov[0]), 64'd1);
        check("post_rst_p", 0, 64'(p8), 64'h000F);
        check("post_rst_tag", 0, 64'(t8), 64'd9);
        @(posedge clk);
        #1;
        chk_lat = 1'b0;
        drain(0);

        // Random traffic with stalls on the 8-bit instance.
        rand_run(0, 2000);

        // WIDTH=4: every operand pair in both modes, random output stalls.
        rnd_stall = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    send(1, 16'(a), 16'(b), 1'(s), 4'(a ^ b));
        rnd_stall = 1'b0;
        drain(1);

        // WIDTH=16: random vectors with stalls.
        rand_run(2, 10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
